// File: rtl/vram_arb_if.sv
// ============================================================================
// Module   : vram_arb_if
// Purpose  : Requester/response and RAM-side bundle for the two-port VRAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vram_arb_if #(
  parameter int ADDRW = 14,
  parameter int DATAW = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_we;
  logic [ADDRW-1:0]   req_addr0;
  logic [ADDRW-1:0]   req_addr1;
  logic [DATAW-1:0]   req_wdata0;
  logic [DATAW-1:0]   req_wdata1;
  logic [DATAW/8-1:0] req_wmask0;
  logic [DATAW/8-1:0] req_wmask1;
  logic [1:0]         rsp_valid;
  logic [DATAW-1:0]   rsp_rdata;
  logic               mem_en;
  logic [DATAW/8-1:0] mem_we;
  logic [ADDRW-1:0]   mem_addr;
  logic [DATAW-1:0]   mem_wdata;
  logic [DATAW-1:0]   mem_rdata;

  // Arbiter view
  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1,
    input  req_wdata0, req_wdata1, req_wmask0, req_wmask1, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester plus RAM view
  modport master (
    output req_valid, req_we, req_addr0, req_addr1,
    output req_wdata0, req_wdata1, req_wmask0, req_wmask1, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/vram_arb.sv
// ============================================================================
// Module   : vram_arb
// Purpose  : Round-robin arbiter sharing one single-port VRAM between two ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_arb #(
  parameter int ADDRW   = 14,
  parameter int DATAW   = 32,
  parameter int MEM_LAT = 1
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        arb_pause,
  vram_arb_if.slave   bus
);
  localparam int MASKW = DATAW / 8;

  logic [1:0]         w_grant;
  logic               w_gport;
  logic               w_xfer;
  logic               w_rd;
  logic               r_last;
  logic [MEM_LAT-1:0] r_pv;
  logic [MEM_LAT-1:0] r_pp;

  // On contention the port that did not win last time is favoured.
  always_comb begin
    w_grant = 2'b00;
    if (!rst_sys && !arb_pause) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_gport = w_grant[1];
  assign w_xfer  = |w_grant;
  assign w_rd    = w_xfer & ~bus.req_we[w_gport];

  assign bus.req_ready = w_grant;
  assign bus.mem_en    = w_xfer;
  assign bus.mem_addr  = w_gport ? bus.req_addr1  : bus.req_addr0;
  assign bus.mem_wdata = w_gport ? bus.req_wdata1 : bus.req_wdata0;
  assign bus.mem_we    = (w_xfer && bus.req_we[w_gport])
                         ? (w_gport ? bus.req_wmask1 : bus.req_wmask0)
                         : {MASKW{1'b0}};

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_last <= 1'b1;
    end else if (w_xfer) begin
      r_last <= w_gport;
    end
  end

  // Read tracker: one (valid, port) stage per cycle of RAM latency.
  generate
    if (MEM_LAT == 1) begin : g_pipe1
      always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
          r_pv <= 1'b0;
          r_pp <= 1'b0;
        end else begin
          r_pv <= w_rd;
          r_pp <= w_gport;
        end
      end
    end else begin : g_pipen
      always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
          r_pv <= '0;
          r_pp <= '0;
        end else begin
          r_pv <= {r_pv[MEM_LAT-2:0], w_rd};
          r_pp <= {r_pp[MEM_LAT-2:0], w_gport};
        end
      end
    end
  endgenerate

  assign bus.rsp_valid = rst_sys ? 2'b00
                         : {r_pv[MEM_LAT-1] & r_pp[MEM_LAT-1],
                            r_pv[MEM_LAT-1] & ~r_pp[MEM_LAT-1]};
  assign bus.rsp_rdata = bus.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_vram_arb.sv
// ============================================================================
// Module   : tb_vram_arb
// Purpose  : Directed bench for vram_arb at MEM_LAT=1 and MEM_LAT=3 with write-first RAM models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vram_arb;
  logic clk_sys = 1'b0;
  logic rst_sys;
  logic arb_pause;
  int   n_checks = 0;
  int   n_fail   = 0;

  vram_arb_if #(.ADDRW(14), .DATAW(32)) bus1 ();
  vram_arb_if #(.ADDRW(14), .DATAW(32)) bus3 ();

  vram_arb #(.ADDRW(14), .DATAW(32), .MEM_LAT(1)) u_dut1 (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .arb_pause(arb_pause), .bus(bus1));
  vram_arb #(.ADDRW(14), .DATAW(32), .MEM_LAT(3)) u_dut3 (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .arb_pause(arb_pause), .bus(bus3));

  always #5 clk_sys = ~clk_sys;

  // Write-first RAM models, latency 1 and 3
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] nx1, nx3, rp1;
  logic [31:0] rp3 [0:2];

  always @(posedge clk_sys) begin
    if (bus1.mem_en) begin
      nx1 = mem1[bus1.mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (bus1.mem_we[b]) nx1[8*b +: 8] = bus1.mem_wdata[8*b +: 8];
      mem1[bus1.mem_addr[7:0]] <= nx1;
      rp1 <= nx1;
    end
  end

  always @(posedge clk_sys) begin
    if (bus3.mem_en) begin
      nx3 = mem3[bus3.mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (bus3.mem_we[b]) nx3[8*b +: 8] = bus3.mem_wdata[8*b +: 8];
      mem3[bus3.mem_addr[7:0]] <= nx3;
      rp3[0] <= nx3;
    end
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  assign bus1.mem_rdata = rp1;
  assign bus3.mem_rdata = rp3[2];

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_buses;
    bus1.req_valid = 2'b00; bus1.req_we = 2'b00;
    bus1.req_addr0 = '0; bus1.req_addr1 = '0;
    bus1.req_wdata0 = '0; bus1.req_wdata1 = '0;
    bus1.req_wmask0 = '0; bus1.req_wmask1 = '0;
    bus3.req_valid = 2'b00; bus3.req_we = 2'b00;
    bus3.req_addr0 = '0; bus3.req_addr1 = '0;
    bus3.req_wdata0 = '0; bus3.req_wdata1 = '0;
    bus3.req_wmask0 = '0; bus3.req_wmask1 = '0;
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the release edge.
  task automatic pulse_reset;
    rst_sys = 1'b1;
    step();
    rst_sys = 1'b0;
  endtask

  task automatic test_reset;
    bus1.req_valid = 2'b11;
    bus3.req_valid = 2'b11;
    #2;
    n_checks++; if (bus1.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready1: got %b exp 00", bus1.req_ready); end
    n_checks++; if (bus1.mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b exp 0", bus1.mem_en); end
    n_checks++; if (bus1.mem_we !== 4'b0000) begin n_fail++; $display("FAIL rst_mem_we: got %b exp 0000", bus1.mem_we); end
    n_checks++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp1: got %b exp 00", bus1.rsp_valid); end
    n_checks++; if (bus3.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready3: got %b exp 00", bus3.req_ready); end
    step();
    rst_sys = 1'b0;
    #1;
    n_checks++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL first_grant: got %b exp 01", bus1.req_ready); end
    bus1.req_valid = 2'b00;
    bus3.req_valid = 2'b00;
    step();
  endtask

  task automatic test_single_read;
    bus1.req_valid = 2'b01; bus1.req_we = 2'b01;
    bus1.req_addr0 = 14'h0010; bus1.req_wdata0 = 32'hDEADBEEF; bus1.req_wmask0 = 4'hF;
    #1;
    n_checks++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b exp 01", bus1.req_ready); end
    n_checks++; if (bus1.mem_we !== 4'hF) begin n_fail++; $display("FAIL wr_mem_we: got %b exp 1111", bus1.mem_we); end
    step();
    bus1.req_we = 2'b00;
    #1;
    n_checks++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_ready: got %b exp 01", bus1.req_ready); end
    n_checks++; if (bus1.mem_en !== 1'b1 || bus1.mem_we !== 4'h0) begin n_fail++; $display("FAIL rd_mem: got en=%b we=%b exp en=1 we=0000", bus1.mem_en, bus1.mem_we); end
    n_checks++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_no_rsp: got %b exp 00", bus1.rsp_valid); end
    step();
    bus1.req_valid = 2'b00;
    #1;
    n_checks++; if (bus1.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_rsp: got %b exp 01", bus1.rsp_valid); end
    n_checks++; if (bus1.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h exp deadbeef", bus1.rsp_rdata); end
    step();
    n_checks++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rd_pulse_end: got %b exp 00", bus1.rsp_valid); end
  endtask

  task automatic test_masked_write;
    bus1.req_valid = 2'b10; bus1.req_we = 2'b10;
    bus1.req_addr1 = 14'h0020; bus1.req_wdata1 = 32'hAABBCCDD; bus1.req_wmask1 = 4'hF;
    step();
    bus1.req_wdata1 = 32'h11223344; bus1.req_wmask1 = 4'b0101;
    #1;
    n_checks++; if (bus1.mem_we !== 4'b0101) begin n_fail++; $display("FAIL mask_we: got %b exp 0101", bus1.mem_we); end
    n_checks++; if (bus1.req_ready !== 2'b10) begin n_fail++; $display("FAIL mask_ready: got %b exp 10", bus1.req_ready); end
    n_checks++; if (bus1.mem_addr !== 14'h0020) begin n_fail++; $display("FAIL mask_addr: got %h exp 0020", bus1.mem_addr); end
    step();
    bus1.req_valid = 2'b00;
    #1;
    n_checks++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mask_no_rsp: got %b exp 00", bus1.rsp_valid); end
    n_checks++; if (bus1.mem_we !== 4'b0000) begin n_fail++; $display("FAIL mask_we_end: got %b exp 0000", bus1.mem_we); end
    step();
    // Zero-mask write still takes the slot and moves last_grant to port 0
    bus1.req_valid = 2'b01; bus1.req_we = 2'b01;
    bus1.req_addr0 = 14'h0020; bus1.req_wdata0 = 32'hFFFFFFFF; bus1.req_wmask0 = 4'h0;
    #1;
    n_checks++; if (bus1.req_ready !== 2'b01 || bus1.mem_en !== 1'b1 || bus1.mem_we !== 4'h0) begin n_fail++; $display("FAIL zmask: got rdy=%b en=%b we=%b exp rdy=01 en=1 we=0000", bus1.req_ready, bus1.mem_en, bus1.mem_we); end
    step();
    bus1.req_valid = 2'b11; bus1.req_we = 2'b00; bus1.req_addr0 = 14'h0010;
    #1;
    n_checks++; if (bus1.req_ready !== 2'b10) begin n_fail++; $display("FAIL zmask_rr: got %b exp 10", bus1.req_ready); end
    step();
    bus1.req_valid = 2'b01;
    #1;
    n_checks++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL rb_ready0: got %b exp 01", bus1.req_ready); end
    n_checks++; if (bus1.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL rb_rsp1: got %b exp 10", bus1.rsp_valid); end
    n_checks++; if (bus1.rsp_rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL rb_data1: got %h exp aa22cc44", bus1.rsp_rdata); end
    step();
    bus1.req_valid = 2'b00;
    #1;
    n_checks++; if (bus1.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rb_rsp0: got %b exp 01", bus1.rsp_valid); end
    n_checks++; if (bus1.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rb_data0: got %h exp deadbeef", bus1.rsp_rdata); end
    step();
  endtask

  task automatic test_pause;
    pulse_reset();
    bus1.req_valid = 2'b11; bus1.req_we = 2'b00;
    bus1.req_addr0 = 14'h0010; bus1.req_addr1 = 14'h0020;
    #1;
    n_checks++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL pz_grant0: got %b exp 01", bus1.req_ready); end
    step();
    bus1.req_valid = 2'b10; arb_pause = 1'b1;
    #1;
    n_checks++; if (bus1.rsp_valid !== 2'b01 || bus1.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pz_rsp0: got %b/%h exp 01/deadbeef", bus1.rsp_valid, bus1.rsp_rdata); end
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (bus1.req_ready !== 2'b00 || bus1.mem_en !== 1'b0) begin n_fail++; $display("FAIL pz_hold[%0d]: got rdy=%b en=%b exp 00/0", c, bus1.req_ready, bus1.mem_en); end
      step();
      #1;
    end
    arb_pause = 1'b0;
    #1;
    n_checks++; if (bus1.req_ready !== 2'b10) begin n_fail++; $display("FAIL pz_release: got %b exp 10", bus1.req_ready); end
    step();
    bus1.req_valid = 2'b00;
    #1;
    n_checks++; if (bus1.rsp_valid !== 2'b10 || bus1.rsp_rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL pz_rsp1: got %b/%h exp 10/aa22cc44", bus1.rsp_valid, bus1.rsp_rdata); end
    step();
  endtask

  task automatic test_contention;
    logic [1:0] g, e1, e3, r1, r3;
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      bus1.req_valid = (c < 6) ? 2'b11 : 2'b00; bus1.req_we = 2'b00;
      bus3.req_valid = (c < 6) ? 2'b11 : 2'b00; bus3.req_we = 2'b00;
      bus1.req_addr0 = 14'h0010; bus1.req_addr1 = 14'h0020;
      bus3.req_addr0 = 14'h0030; bus3.req_addr1 = 14'h0040;
      g  = (c < 6) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      e1 = (c >= 1 && c <= 6) ? (((c - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      e3 = (c >= 3 && c <= 8) ? (((c - 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      #1;
      r1 = bus1.rsp_valid;
      r3 = bus3.rsp_valid;
      n_checks++; if (bus1.req_ready !== g) begin n_fail++; $display("FAIL ct_grant1[%0d]: got %b exp %b", c, bus1.req_ready, g); end
      n_checks++; if (bus3.req_ready !== g) begin n_fail++; $display("FAIL ct_grant3[%0d]: got %b exp %b", c, bus3.req_ready, g); end
      n_checks++; if (r1 !== e1) begin n_fail++; $display("FAIL ct_rsp1[%0d]: got %b exp %b", c, r1, e1); end
      n_checks++; if (r3 !== e3) begin n_fail++; $display("FAIL ct_rsp3[%0d]: got %b exp %b", c, r3, e3); end
      step();
    end
  endtask

  task automatic test_reset_midflight;
    pulse_reset();
    bus3.req_valid = 2'b01; bus3.req_we = 2'b00; bus3.req_addr0 = 14'h0010;
    step();
    bus3.req_addr0 = 14'h0011;
    #1;
    n_checks++; if (bus3.req_ready !== 2'b01) begin n_fail++; $display("FAIL mf_issue2: got %b exp 01", bus3.req_ready); end
    step();
    bus3.req_valid = 2'b11;
    #2;
    rst_sys = 1'b1;
    #1;
    n_checks++; if (bus3.req_ready !== 2'b00 || bus3.mem_en !== 1'b0) begin n_fail++; $display("FAIL mf_gate: got rdy=%b en=%b exp 00/0", bus3.req_ready, bus3.mem_en); end
    for (int c = 3; c <= 4; c++) begin
      step();
      n_checks++; if (bus3.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mf_dropped[%0d]: got %b exp 00", c, bus3.rsp_valid); end
    end
    step();
    rst_sys = 1'b0;
    #1;
    n_checks++; if (bus3.req_ready !== 2'b01) begin n_fail++; $display("FAIL mf_post_grant0: got %b exp 01", bus3.req_ready); end
    n_checks++; if (bus3.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mf_rsp_c5: got %b exp 00", bus3.rsp_valid); end
    step();
    n_checks++; if (bus3.req_ready !== 2'b10) begin n_fail++; $display("FAIL mf_post_grant1: got %b exp 10", bus3.req_ready); end
    n_checks++; if (bus3.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mf_rsp_c6: got %b exp 00", bus3.rsp_valid); end
    bus3.req_valid = 2'b00;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_streaming;
    logic [1:0] er, ev;
    for (int c = 0; c < 10; c++) begin
      bus1.req_valid = (c < 8) ? 2'b10 : 2'b00; bus1.req_we = 2'b00;
      bus1.req_addr1 = 14'h0020 + 14'(c);
      er = (c < 8) ? 2'b10 : 2'b00;
      ev = (c >= 1 && c <= 8) ? 2'b10 : 2'b00;
      #1;
      n_checks++; if (bus1.req_ready !== er) begin n_fail++; $display("FAIL st_ready[%0d]: got %b exp %b", c, bus1.req_ready, er); end
      n_checks++; if (bus1.rsp_valid !== ev) begin n_fail++; $display("FAIL st_rsp[%0d]: got %b exp %b", c, bus1.rsp_valid, ev); end
      if (c == 1) begin
        n_checks++; if (bus1.rsp_rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL st_data: got %h exp aa22cc44", bus1.rsp_rdata); end
      end
      step();
    end
  endtask

  initial begin
    rst_sys   = 1'b1;
    arb_pause = 1'b0;
    idle_buses();
    test_reset();
    test_single_read();
    test_masked_write();
    test_pause();
    test_contention();
    test_reset_midflight();
    test_streaming();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vram_arb.md
Name: vram_arb

Overview:
- Two-port round-robin arbiter that shares one single-port video RAM (textmap/glyph store) between two system-side requesters.
- Typical requesters: port 0 is the CPU/host bus, port 1 is a console/blitter engine that writes text cells.
- Runs entirely in the system clock domain. It sits between the requesters and the RAM that the text-mode display block reads.
- Issues at most one memory access per cycle and routes read responses back to the issuing port in order.

Parameters:
- ADDRW, 14, memory word address width (bits).
- DATAW, 32, memory data width (bits); must be a multiple of 8.
- MEM_LAT, 1, RAM read latency in cycles, from the enable edge to valid mem_rdata; legal range 1-4.

Ports:
- clk_sys  in  1  system clock.
- rst_sys  in  1  reset; asynchronous, active-high.
- arb_pause  in  1  when high, no new grants are issued; in-flight reads still complete.
- req_valid  in  2  request valid, bit i = port i.
- req_ready  out  2  request accepted this cycle, bit i = port i.
- req_we  in  2  1 = write, 0 = read, per port.
- req_addr0, req_addr1  in  ADDRW  word address, per port.
- req_wdata0, req_wdata1  in  DATAW  write data, per port.
- req_wmask0, req_wmask1  in  DATAW/8  byte write enables, per port.
- rsp_valid  out  2  one-cycle read-data-valid pulse, per port.
- rsp_rdata  out  DATAW  read data, shared by both ports and qualified by rsp_valid.
- mem_en  out  1  RAM access enable.
- mem_we  out  DATAW/8  RAM byte write enables.
- mem_addr  out  ADDRW  RAM address.
- mem_wdata  out  DATAW  RAM write data.
- mem_rdata  in  DATAW  RAM read data.

Behaviour:
- Transfer on port i: req_valid[i] & req_ready[i] at a rising edge of clk_sys.
- Handshake rules:
  - Requesters hold valid and payload stable until accepted.
  - req_ready may depend combinationally on req_valid; requesters must not make valid depend on ready.
- Grant logic (combinational):
  - If arb_pause or rst_sys is high: grant nothing.
  - Else if only one port is valid: grant that port.
  - Else if both are valid: grant the port that is not last_grant.
  - req_ready = grant; at most one bit is set; req_ready is 0 for a non-valid port.
- last_grant register:
  - Updated to the granted port on every transfer; holds otherwise.
  - Reset value is 1, so port 0 wins the first contention.
  - Under continuous contention the grants alternate 0,1,0,1.
- Memory drive (combinational from the granted port):
  - mem_en = |grant.
  - mem_addr and mem_wdata are muxed from the granted port.
  - mem_we = wmask of the granted port when its we=1, else 0.
  - With no grant: mem_en = 0, mem_we = 0; mem_addr and mem_wdata hold the port 0 values (don't-care).
- Write with all-zero wmask: still a transfer; it consumes the slot and updates last_grant, but changes no memory.
- Response tracking:
  - A shift register of depth MEM_LAT holds (valid, port) per stage.
  - Stage 0 is loaded on each edge with {transfer & ~we, granted port}.
  - rsp_valid[p] = last stage valid & last stage port == p.
  - rsp_rdata = mem_rdata passed through combinationally.
  - Read accepted at edge k: rsp_valid pulses for exactly one cycle, in the cycle following edge k+MEM_LAT-1.
  - Responses come back in issue order; no backpressure on responses.
  - Back-to-back reads give back-to-back rsp_valid pulses.
- Writes generate no response.
- Read-after-write to the same address on consecutive cycles returns the new data; this relies on RAM write-first behaviour and is not handled by the arbiter.
- arb_pause:
  - Blocks new grants only; the pipeline keeps shifting.
  - last_grant holds while paused.
  - Deasserting pause re-enables grants in the same cycle.
- Reset (asynchronous assert, any time including mid-operation):
  - Pipeline valids cleared; in-flight reads are dropped and never respond.
  - rsp_valid = 0, req_ready = 0, mem_en = 0, mem_we = 0, last_grant = 1.
  - First grant possible in the first cycle after rst_sys deasserts.
- Outputs at reset:
  - Combinational outputs are gated by rst_sys.
  - rsp_rdata follows mem_rdata and is meaningless without rsp_valid.

Test Plan:
- Reset then single read: port 0 reads addr 0x0010, RAM holds 0xDEADBEEF, MEM_LAT=1 → req_ready[0] high in the request cycle; rsp_valid = 2'b01 one cycle later with rsp_rdata = 0xDEADBEEF; rsp_valid[1] stays 0.
- Contention fairness: both ports hold valid reads for 6 cycles from reset → grant order 0,1,0,1,0,1; the rsp_valid port sequence matches the grant order, each delayed by MEM_LAT (repeat with MEM_LAT=3).
- Byte-masked write: port 1 writes 0x11223344 with wmask 4'b0101 to 0x0020 (previous contents 0xAABBCCDD) → mem_we = 4'b0101 for one cycle; a later read returns 0xAA22CC44; no rsp_valid for the write.
- Pause: set arb_pause the cycle after port 0 issues a read while port 1 is valid → port 0's rsp_valid still pulses; req_ready = 0 for 4 paused cycles; on release port 1 is granted in the same cycle.
- Reset mid-flight: MEM_LAT=3, issue reads at two consecutive edges, assert rst_sys asynchronously one cycle later → rsp_valid never pulses; after release, contention grants port 0 first.
- Single-requester streaming: port 1 valid for 8 cycles with port 0 idle → req_ready[1] high every cycle; 8 consecutive rsp_valid[1] pulses.
